// File: rtl/hdmi_event_status.sv
// Turns HDMI pipeline event pulses into software-visible toggle bits, tracks fill requests
// against the software fill toggle (acknowledge), and keeps line/frame counters.
module hdmi_event_status #(
  parameter int unsigned LINE_W  = 12,
  parameter int unsigned FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_half_I,
  input  logic               hsync_I,
  input  logic               vsync_I,
  input  logic               fill_ack_I,
  input  logic               clr_I,
  output logic               fifo_half_O,
  output logic               hsync_O,
  output logic               vsync_O,
  output logic               fill_pending_O,
  output logic               overrun_O,
  output logic [LINE_W-1:0]  line_count_O,
  output logic [LINE_W-1:0]  line_last_O,
  output logic [FRAME_W-1:0] frame_count_O
);

  localparam logic StArm = 1'b0;
  localparam logic StRun = 1'b1;

  localparam logic [LINE_W-1:0] LineMax = {LINE_W{1'b1}};

  logic               state_q, state_d;
  logic               prev_ack_q, prev_clr_q;
  logic               half_q, hsync_q, vsync_q;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic [LINE_W-1:0]  line_q, line_d, last_q, last_d, line_inc;
  logic [FRAME_W-1:0] frame_q;
  logic               ack_ev, clr_ev;

  // The ARM cycle only samples the toggle registers, so a toggle already at 1 is not an event.
  assign ack_ev   = (state_q == StRun) & (fill_ack_I ^ prev_ack_q);
  assign clr_ev   = (state_q == StRun) & (clr_I ^ prev_clr_q);
  assign line_inc = (line_q == LineMax) ? line_q : line_q + 1'b1;

  always_comb begin
    state_d   = StRun;
    pending_d = pending_q;
    overrun_d = overrun_q;
    line_d    = line_q;
    last_d    = last_q;
    if (fifo_half_I) begin
      pending_d = 1'b1;
    end else if (ack_ev) begin
      pending_d = 1'b0;
    end
    // A new request while one is outstanding wins over a simultaneous clear.
    if (fifo_half_I && pending_q && !ack_ev) begin
      overrun_d = 1'b1;
    end else if (clr_ev) begin
      overrun_d = 1'b0;
    end
    if (vsync_I) begin
      last_d = hsync_I ? line_inc : line_q;
      line_d = hsync_I ? LINE_W'(1) : '0;
    end else if (hsync_I) begin
      line_d = line_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StArm;
      prev_ack_q <= 1'b0;
      prev_clr_q <= 1'b0;
      half_q     <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      line_q     <= '0;
      last_q     <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_ack_q <= fill_ack_I;
      prev_clr_q <= clr_I;
      half_q     <= half_q ^ fifo_half_I;
      hsync_q    <= hsync_q ^ hsync_I;
      vsync_q    <= vsync_q ^ vsync_I;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      line_q     <= line_d;
      last_q     <= last_d;
      frame_q    <= frame_q + FRAME_W'(vsync_I);
    end
  end

  assign fifo_half_O    = half_q;
  assign hsync_O        = hsync_q;
  assign vsync_O        = vsync_q;
  assign fill_pending_O = pending_q;
  assign overrun_O      = overrun_q;
  assign line_count_O   = line_q;
  assign line_last_O    = last_q;
  assign frame_count_O  = frame_q;

endmodule

// File: tb/tb_hdmi_event_status.sv
// Scoreboard bench for hdmi_event_status with narrow counters (LINE_W=4, FRAME_W=2).
module tb_hdmi_event_status;

  localparam int unsigned LW = 4;
  localparam int unsigned FW = 2;

  typedef struct packed {
    logic          half;
    logic          hs;
    logic          vs;
    logic          pend;
    logic          ovr;
    logic [LW-1:0] line;
    logic [LW-1:0] last;
    logic [FW-1:0] frame;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_half_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0, fill_ack_i = 1'b0, clr_i = 1'b0;
  logic fifo_half_o, hsync_o, vsync_o, fill_pending_o, overrun_o;
  logic [LW-1:0] line_count_o, line_last_o;
  logic [FW-1:0] frame_count_o;

  hdmi_event_status #(.LINE_W(LW), .FRAME_W(FW)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_half_I    (fifo_half_i),
    .hsync_I        (hsync_i),
    .vsync_I        (vsync_i),
    .fill_ack_I     (fill_ack_i),
    .clr_I          (clr_i),
    .fifo_half_O    (fifo_half_o),
    .hsync_O        (hsync_o),
    .vsync_O        (vsync_o),
    .fill_pending_O (fill_pending_o),
    .overrun_O      (overrun_o),
    .line_count_O   (line_count_o),
    .line_last_O    (line_last_o),
    .frame_count_O  (frame_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  obs_t exp_q[$];

  // Reference model state: plain integers and flags.
  int m_half, m_hs, m_vs, m_pend, m_ovr, m_line, m_last, m_frame;
  int m_prev_ack, m_prev_clr, m_first;
  logic ack_lvl = 1'b0, clr_lvl = 1'b0;

  function automatic obs_t dut_obs();
    return {fifo_half_o, hsync_o, vsync_o, fill_pending_o, overrun_o,
            line_count_o, line_last_o, frame_count_o};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.half  = m_half[0];
    o.hs    = m_hs[0];
    o.vs    = m_vs[0];
    o.pend  = m_pend[0];
    o.ovr   = m_ovr[0];
    o.line  = LW'(m_line);
    o.last  = LW'(m_last);
    o.frame = FW'(m_frame);
    return o;
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s at %0t: got %h required %h", name, $time, got, want);
  endtask

  task automatic model_reset();
    m_half = 0; m_hs = 0; m_vs = 0; m_pend = 0; m_ovr = 0;
    m_line = 0; m_last = 0; m_frame = 0;
    m_prev_ack = 0; m_prev_clr = 0; m_first = 1;
  endtask

  // Drive one clock cycle of inputs and predict the outputs after the next rising edge.
  task automatic step(input bit fh, input bit hs, input bit vs, input bit tog_ack,
                      input bit tog_clr);
    int  line_max;
    bit  ack_ev, clr_ev;
    @(negedge clk);
    if (tog_ack) ack_lvl = ~ack_lvl;
    if (tog_clr) clr_lvl = ~clr_lvl;
    fifo_half_i = fh; hsync_i = hs; vsync_i = vs; fill_ack_i = ack_lvl; clr_i = clr_lvl;
    line_max = (1 << LW) - 1;
    ack_ev = !m_first && (int'(ack_lvl) != m_prev_ack);
    clr_ev = !m_first && (int'(clr_lvl) != m_prev_clr);
    if (fh && m_pend && !ack_ev) m_ovr = 1;
    else if (clr_ev) m_ovr = 0;
    if (fh) m_pend = 1;
    else if (ack_ev) m_pend = 0;
    m_half ^= int'(fh); m_hs ^= int'(hs); m_vs ^= int'(vs);
    if (vs) begin
      m_last  = (m_line + int'(hs) > line_max) ? line_max : m_line + int'(hs);
      m_line  = int'(hs);
      m_frame = (m_frame + 1) % (1 << FW);
    end else if (hs) begin
      m_line = (m_line + 1 > line_max) ? line_max : m_line + 1;
    end
    m_prev_ack = int'(ack_lvl); m_prev_clr = int'(clr_lvl); m_first = 0;
    exp_q.push_back(model_obs());
  endtask

  // Assert reset between edges, confirm it acts without a clock, hold it, then release.
  task automatic do_reset(input int hold);
    @(negedge clk);
    rst = 1'b1;
    fifo_half_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    model_reset();
    #1;
    compare("async_reset", dut_obs(), model_obs());
    for (int i = 0; i < hold; i++) begin
      exp_q.push_back(model_obs());
      @(negedge clk);
    end
    rst = 1'b0;
    exp_q.push_back(model_obs());
  endtask

  // Monitor: outputs are valid every cycle; compare one expectation per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare("cycle", dut_obs(), exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    // Reset with the ack toggle held high: the ARM cycle must not see an acknowledge.
    ack_lvl = 1'b1; fill_ack_i = 1'b1;
    do_reset(2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Request, then acknowledge five cycles later.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // Overrun, clear, then clear racing a new overrunning request.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // Clear, then request and ack together while pending.
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // Line saturation and vsync capture.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Frame wrap with a reset in the middle.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    do_reset(1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 2));
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
